// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter in front of a single-port synchronous memory
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req, i_addr               port 0 (instruction fetch) read request and address
//   i_gnt, i_rvalid, i_rdata    port 0 command-issued pulse, read-data-valid pulse, read data
//   d_req, d_we, d_addr,
//   d_wdata                     port 1 (data) request, write enable, address, write data
//   d_gnt, d_rvalid, d_rdata    port 1 command-issued pulse, read-data-valid pulse, read data
//   mem_wren, mem_rden,
//   mem_addr, mem_d             registered memory command
//   mem_q                       memory read data, valid the cycle after mem_rden
//   busy                        high while a transfer is in flight

module mem_arbiter #(
    parameter int ADDRSIZE = 16,
    parameter int WORDSIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDRSIZE-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORDSIZE-1:0] i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDRSIZE-1:0] d_addr,
    input  logic [WORDSIZE-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORDSIZE-1:0] d_rdata,
    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic                accept;
    logic                win_port;    // 0 = port 0, 1 = port 1
    logic                win_we;
    logic                last_port;   // port granted most recently
    logic                cap_port;
    logic                cap_we;
    logic [WORDSIZE-1:0] i_hold;
    logic [WORDSIZE-1:0] d_hold;

    // Under contention the port not granted last wins; otherwise the lone requester wins.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        win_port  = (i_req && d_req) ? ~last_port : d_req;
        win_we    = win_port & d_we;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE:   state_nxt = cap_we ? IDLE : RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The command registers are loaded on the accept edge so that the memory
    // command and grant are visible for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wren  <= 1'b0;
            mem_rden  <= 1'b0;
            mem_addr  <= '0;
            mem_d     <= '0;
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            cap_port  <= 1'b0;
            cap_we    <= 1'b0;
            last_port <= 1'b1;        // port 0 wins the first contention
            i_hold    <= '0;
            d_hold    <= '0;
        end else begin
            mem_wren <= 1'b0;
            mem_rden <= 1'b0;
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            if (accept) begin
                cap_port <= win_port;
                cap_we   <= win_we;
                mem_addr <= win_port ? d_addr : i_addr;
                mem_d    <= win_port ? d_wdata : '0;
                mem_wren <= win_we;
                mem_rden <= ~win_we;
                i_gnt    <= ~win_port;
                d_gnt    <= win_port;
            end
            if (state == ISSUE) begin
                last_port <= cap_port;
            end
            if (i_rvalid) begin
                i_hold <= mem_q;
            end
            if (d_rvalid) begin
                d_hold <= mem_q;
            end
        end
    end

    // Read data is passed straight from mem_q during RESP and held afterwards.
    assign busy     = (state != IDLE);
    assign i_rvalid = (state == RESP) && !cap_port;
    assign d_rvalid = (state == RESP) &&  cap_port;
    assign i_rdata  = i_rvalid ? mem_q : i_hold;
    assign d_rdata  = d_rvalid ? mem_q : d_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [3:0]  i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [3:0]  d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [3:0]  d_rdata;
    logic        mem_wren;
    logic        mem_rden;
    logic [15:0] mem_addr;
    logic [3:0]  mem_d;
    logic [3:0]  mem_q;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int pend_i = 0;
    int pend_d = 0;
    int last_g = 1;

    logic [3:0] mem     [16];
    logic [3:0] ref_mem [16];

    mem_arbiter #(.ADDRSIZE(16), .WORDSIZE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_wren (mem_wren),
        .mem_rden (mem_rden),
        .mem_addr (mem_addr),
        .mem_d    (mem_d),
        .mem_q    (mem_q),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[3:0]] <= mem_d;
        if (mem_rden) mem_q <= mem[mem_addr[3:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},    32'({i_gnt, d_gnt}), 32'd0);
        check({tag, "_rvalid"}, 32'({i_rvalid, d_rvalid}), 32'd0);
        check({tag, "_rdata"},  32'({i_rdata, d_rdata}), 32'd0);
        check({tag, "_strobe"}, 32'({mem_wren, mem_rden}), 32'd0);
        check({tag, "_maddr"},  32'(mem_addr), 32'd0);
        check({tag, "_md"},     32'(mem_d), 32'd0);
        check({tag, "_busy"},   32'(busy), 32'd0);
    endtask

    // One isolated transfer: grant and command one cycle after the sample
    // edge, read data one cycle later, idle on the following cycle.
    task automatic xfer(input logic port, input logic we, input logic [15:0] addr, input logic [3:0] wd);
        logic rd;
        logic [3:0] exp_d;
        rd = !(port && we);
        @(negedge clk);
        d_we = we;
        if (port) begin
            d_req = 1'b1; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        @(negedge clk);
        check("x_gnt",  32'({i_gnt, d_gnt}), port ? 32'd1 : 32'd2);
        check("x_rden", 32'(mem_rden), 32'(rd));
        check("x_wren", 32'(mem_wren), 32'(!rd));
        check("x_addr", 32'(mem_addr), 32'(addr));
        if (!rd) check("x_wdata", 32'(mem_d), 32'(wd));
        check("x_busy", 32'(busy), 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        last_g = int'(port);
        if (!rd) ref_mem[addr[3:0]] = wd;
        exp_d = ref_mem[addr[3:0]];
        @(negedge clk);
        if (rd) begin
            check("x_rvalid", 32'({i_rvalid, d_rvalid}), port ? 32'd1 : 32'd2);
            check("x_rdata",  32'(port ? d_rdata : i_rdata), 32'(exp_d));
            @(negedge clk);
            check("x_hold",   32'(port ? d_rdata : i_rdata), 32'(exp_d));
        end
        check("x_norv", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("x_idle", 32'(busy), 32'd0);
    endtask

    // Protocol monitor running for the whole simulation.
    initial begin
        forever begin
            @(negedge clk);
            check("p_excl", 32'(mem_wren && mem_rden), 32'd0);
            check("p_gnt2", 32'(i_gnt && d_gnt), 32'd0);
            check("p_rv2",  32'(i_rvalid && d_rvalid), 32'd0);
            if (!rst_n) begin
                pend_i = 0; pend_d = 0;
            end else begin
                if (i_rvalid) begin check("p_i_rv", 32'(pend_i), 32'd1); pend_i--; end
                if (d_rvalid) begin check("p_d_rv", 32'(pend_d), 32'd1); pend_d--; end
                if (i_gnt && mem_rden) pend_i++;
                if (d_gnt && mem_rden) pend_d++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r;
        logic        w;
        logic        rd;
        logic [15:0] ia;
        logic [15:0] da;
        logic        dw;
        logic [3:0]  dd;
        logic        exp_port;
        int          prev;
        int          grants;

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #12;
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single write, then single read of a known word
        xfer(1'b1, 1'b1, 16'd3, 4'hA);
        xfer(1'b1, 1'b1, 16'd5, 4'h9);
        xfer(1'b0, 1'b0, 16'd5, 4'h0);
        xfer(1'b0, 1'b1, 16'd3, 4'h0);   // port 0 ignores d_we

        // fill and read back
        for (int a = 0; a < 16; a++) xfer(1'b1, 1'b1, 16'(a), 4'(15 - a));
        for (int a = 15; a >= 0; a--) begin
            xfer(1'b0, 1'b0, 16'(a), 4'h0);
            check("fill_ref", 32'(i_rdata), 32'(15 - a));
        end

        // request withdrawn right after the sample edge still completes
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'd2;
        @(posedge clk);
        #1 i_req = 1'b0;
        @(negedge clk);
        check("wd_gnt", 32'(i_gnt), 32'd1);
        last_g = 0;
        @(negedge clk);
        check("wd_rvalid", 32'(i_rvalid), 32'd1);
        check("wd_rdata",  32'(i_rdata), 32'(ref_mem[2]));
        @(negedge clk);
        check("wd_idle", 32'(busy), 32'd0);

        // randomized single and contending requests
        for (int it = 0; it < 40; it++) begin
            @(negedge clk);
            r  = 2'($urandom_range(1, 3));
            ia = 16'($urandom);
            da = 16'($urandom);
            dw = 1'($urandom_range(0, 1));
            dd = 4'($urandom);
            i_req = r[0]; i_addr = ia;
            d_req = r[1]; d_addr = da; d_we = dw; d_wdata = dd;
            w  = (r == 2'b11) ? (last_g == 0) : r[1];
            rd = !(w && dw);
            @(negedge clk);
            check("r_gnt",  32'({i_gnt, d_gnt}), w ? 32'd1 : 32'd2);
            check("r_rden", 32'(mem_rden), 32'(rd));
            check("r_wren", 32'(mem_wren), 32'(!rd));
            check("r_addr", 32'(mem_addr), 32'(w ? da : ia));
            i_req = 1'b0; d_req = 1'b0;
            last_g = int'(w);
            if (!rd) ref_mem[da[3:0]] = dd;
            @(negedge clk);
            if (rd) begin
                check("r_rvalid", 32'({i_rvalid, d_rvalid}), w ? 32'd1 : 32'd2);
                check("r_rdata",  32'(w ? d_rdata : i_rdata), 32'(ref_mem[w ? da[3:0] : ia[3:0]]));
                @(negedge clk);
            end
            check("r_idle", 32'(busy), 32'd0);
        end

        // reset dropped during RESP aborts the read at once
        @(negedge clk);
        i_req = 1'b1; i_addr = 16'd7;
        @(negedge clk);
        check("rr_gnt", 32'(i_gnt), 32'd1);
        i_req = 1'b0;
        @(posedge clk);
        #2;
        check("rr_resp", 32'(i_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("rr");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_g = 1;
        @(negedge clk);
        check("rr_idle", 32'(busy), 32'd0);

        // both ports held high: alternate from port 0, back-to-back every 3 cycles
        i_req = 1'b1; i_addr = 16'($urandom);
        d_req = 1'b1; d_addr = 16'($urandom); d_we = 1'b0;
        exp_port = (last_g == 0);
        prev = -1;
        grants = 0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            @(negedge clk);
            if (i_rvalid) check("c_irdata", 32'(i_rdata), 32'(ref_mem[i_addr[3:0]]));
            if (d_rvalid) check("c_drdata", 32'(d_rdata), 32'(ref_mem[d_addr[3:0]]));
            if (i_gnt || d_gnt) begin
                check("c_port", 32'({i_gnt, d_gnt}), exp_port ? 32'd1 : 32'd2);
                if (prev >= 0) check("c_gap", 32'(c - prev), 32'd3);
                prev = c;
                exp_port = !exp_port;
                grants++;
            end
        end
        check("c_grants", 32'(grants), 32'd6);
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        check("c_lrv", 32'(d_rvalid), 32'd1);
        check("c_lrdata", 32'(d_rdata), 32'(ref_mem[d_addr[3:0]]));
        @(negedge clk);
        check("c_idle", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        check("p_pend_i", 32'(pend_i), 32'd0);
        check("p_pend_d", 32'(pend_d), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRSIZE, default 16, SHALL set the memory address width in bits.
REQ-002 Parameter WORDSIZE, default 4, SHALL set the memory data word width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_req  input  1  SHALL be the port 0 (instruction fetch, read-only) request.
REQ-006 i_addr  input  ADDRSIZE  SHALL be the port 0 read address.
REQ-007 i_gnt  output  1  SHALL pulse for one cycle when the port 0 command is issued to memory.
REQ-008 i_rvalid  output  1  SHALL pulse for one cycle when i_rdata is valid.
REQ-009 i_rdata  output  WORDSIZE  SHALL be the port 0 read data.
REQ-010 d_req  input  1  SHALL be the port 1 (data, read/write) request.
REQ-011 d_we  input  1  SHALL select a write (1) or a read (0) for port 1.
REQ-012 d_addr  input  ADDRSIZE  SHALL be the port 1 address.
REQ-013 d_wdata  input  WORDSIZE  SHALL be the port 1 write data.
REQ-014 d_gnt, d_rvalid, d_rdata  output  1/1/WORDSIZE  SHALL have the same meaning as the port 0 signals, applied to port 1.
REQ-015 mem_wren, mem_rden  output  1/1  SHALL be the registered write and read strobes to the memory.
REQ-016 mem_addr, mem_d  output  ADDRSIZE/WORDSIZE  SHALL be the registered address and write data to the memory.
REQ-017 mem_q  input  WORDSIZE  SHALL carry memory read data, valid on the cycle after the cycle in which mem_rden is high.
REQ-018 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states, IDLE, ISSUE and RESP, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-020 In IDLE, when at least one request is sampled high, the block SHALL capture the winner's address, write data, write-enable and port ID into registers and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: with both requests high, the port that was not granted last wins; with one request high, that port wins.
REQ-022 The last-granted pointer SHALL update only on a grant.
REQ-023 In ISSUE, for exactly one cycle, the block SHALL drive mem_addr and mem_d from the captured values, assert mem_rden (read) or mem_wren (write), and assert the winner's gnt.
REQ-024 After ISSUE, a write SHALL go to IDLE and a read SHALL go to RESP.
REQ-025 In RESP, for one cycle, the block SHALL assert the winner's rvalid with rdata equal to mem_q, then go to IDLE.
REQ-026 Read latency SHALL be 2 cycles from the request-sample edge to rvalid; a read occupies 3 cycles and a write 2 cycles.
REQ-027 Back-to-back requests SHALL be accepted again on the first IDLE cycle, with no extra idle cycle.
REQ-028 Requests SHALL be ignored while busy is high.
REQ-029 A request withdrawn after capture SHALL still complete.
REQ-030 The requester SHALL hold its request until gnt, and SHALL deassert it or present a new transfer on the cycle after gnt.
REQ-031 mem_wren and mem_rden SHALL never be high together, and at most one gnt and at most one rvalid SHALL be high in any cycle.
REQ-032 i_rdata and d_rdata SHALL hold their last valid value while the matching rvalid is low.
REQ-033 d_we SHALL be ignored for port 0; port 0 SHALL always issue reads.

Reset
REQ-034 When rst_n is low, the following SHALL apply immediately, independent of clk:
- FSM goes to IDLE.
- All outputs go to 0: mem_wren, mem_rden, mem_addr, mem_d, both gnt, both rvalid, both rdata, busy.
- The last-granted pointer is set so that port 0 wins the first contention.
REQ-035 A reset asserted during ISSUE or RESP SHALL abort the transfer with no rvalid, and the first cycle after release SHALL be IDLE.

Verification
REQ-036 Single read: i_req=1, i_addr=5, mem_q returns 9 -> mem_rden=1 and i_gnt=1 at edge+1; i_rvalid=1 with i_rdata=9 at edge+2; busy low by edge+3.
REQ-037 Single write: d_req=1, d_we=1, d_addr=3, d_wdata=0xA -> mem_wren=1, mem_addr=3, mem_d=0xA, d_gnt=1 for one cycle; no d_rvalid.
REQ-038 Contention: i_req and d_req held high after reset -> grant order is port 0, port 1, port 0, port 1, and no port is granted twice in a row.
REQ-039 Fill and read back: write addresses 0..15 with data 15-addr via port 1, then read 15..0 via port 0 -> every i_rdata equals 15-addr.
REQ-040 Reset mid-read: drop rst_n during RESP -> all outputs 0 at once, no rvalid; a new request after release completes normally.
REQ-041 Protocol checker in all tests: no cycle with mem_wren and mem_rden both high, no double gnt, and exactly one rvalid per granted read.
